// File: rtl/pwm_multi_generator.sv
// Byte-frame decoder feeding NUM_CH PWM channels; new settings are held
// in shadow registers and applied only at each channel's period boundary.
module pwm_multi_generator #(
    parameter int NUM_CH         = 4,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PWM_FIFO_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      empty,
    input  logic [PWM_FIFO_WIDTH-1:0] i_data,
    output logic                      read,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic [NUM_CH-1:0]         ch_active,
    output logic                      frame_done,
    output logic                      frame_err
);
    localparam int FRAME_BYTES = 1 + 2 * COUNTER_WIDTH / 8;
    localparam int ASM_W       = 8 * FRAME_BYTES;
    localparam int BC_W        = $clog2(FRAME_BYTES + 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(FRAME_BYTES - 1);
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAPTURE,
        S_COMMIT
    } state_t;

    state_t            state, state_n;
    logic [BC_W-1:0]   byte_cnt;
    logic [ASM_W-1:0]  asm_q;

    logic [7:0]               hdr;
    logic [COUNTER_WIDTH-1:0] h_new, l_new;
    logic                     idx_ok, commit_ok;

    assign hdr       = asm_q[ASM_W-1 -: 8];
    assign h_new     = asm_q[2*COUNTER_WIDTH-1 -: COUNTER_WIDTH];
    assign l_new     = asm_q[COUNTER_WIDTH-1:0];
    assign idx_ok    = ({1'b0, hdr[5:0]} < 7'(NUM_CH));
    assign commit_ok = (state == S_COMMIT) && idx_ok;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (!empty) state_n = S_REQ;
            S_REQ:     state_n = S_CAPTURE;
            S_CAPTURE: state_n = (byte_cnt == LAST_BYTE) ? S_COMMIT : S_IDLE;
            S_COMMIT:  state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            read       <= 1'b0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            read       <= (state_n == S_REQ);
            frame_done <= commit_ok;
            frame_err  <= (state == S_COMMIT) && !idx_ok;
            if (state == S_CAPTURE) begin
                asm_q    <= {asm_q[ASM_W-9:0], i_data};
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == S_COMMIT) byte_cnt <= '0;
        end
    end

    // shadow (written by frames) and applied (running) channel settings
    logic [NUM_CH-1:0]        en_s, pol_s, pend;
    logic [COUNTER_WIDTH-1:0] h_s [NUM_CH];
    logic [COUNTER_WIDTH-1:0] l_s [NUM_CH];
    logic [NUM_CH-1:0]        en_a, pol_a, ph_hi;
    logic [COUNTER_WIDTH-1:0] h_a [NUM_CH];
    logic [COUNTER_WIDTH-1:0] l_a [NUM_CH];
    logic [COUNTER_WIDTH-1:0] cnt [NUM_CH];

    logic [NUM_CH-1:0]        hit, bnd, load;
    logic [NUM_CH-1:0]        en_n, pol_n, ph_hi_n, pwm_n;
    logic [COUNTER_WIDTH-1:0] h_n   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] l_n   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] cnt_n [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]  = commit_ok && (hdr[5:0] == 6'(i));
            bnd[i]  = !en_a[i] ||
                      ((cnt[i] == '0) && (!ph_hi[i] || (l_a[i] == '0)));
            load[i] = bnd[i] && pend[i];

            en_n[i]    = load[i] ? en_s[i]  : en_a[i];
            pol_n[i]   = load[i] ? pol_s[i] : pol_a[i];
            h_n[i]     = load[i] ? h_s[i]   : h_a[i];
            l_n[i]     = load[i] ? l_s[i]   : l_a[i];
            ph_hi_n[i] = ph_hi[i];
            cnt_n[i]   = cnt[i];

            if (load[i] || (bnd[i] && en_a[i])) begin
                if (h_n[i] != '0) begin
                    ph_hi_n[i] = 1'b1;
                    cnt_n[i]   = h_n[i] - ONE;
                end else begin
                    ph_hi_n[i] = 1'b0;
                    cnt_n[i]   = (l_n[i] == '0) ? '0 : l_n[i] - ONE;
                end
            end else if (!bnd[i]) begin
                // not a boundary here implies L>0 whenever HIGH hits zero
                if (ph_hi[i] && (cnt[i] == '0)) begin
                    ph_hi_n[i] = 1'b0;
                    cnt_n[i]   = l_a[i] - ONE;
                end else begin
                    cnt_n[i] = cnt[i] - ONE;
                end
            end

            pwm_n[i] = en_n[i] ? (ph_hi_n[i] ^ pol_n[i]) : pol_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_s    <= '0;
            pol_s   <= '0;
            pend    <= '0;
            en_a    <= '0;
            pol_a   <= '0;
            ph_hi   <= '0;
            pwm_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                h_s[i] <= '0;
                l_s[i] <= '0;
                h_a[i] <= '0;
                l_a[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            // a commit in the same cycle as a load re-arms pending
            pend    <= hit | (pend & ~load);
            en_a    <= en_n;
            pol_a   <= pol_n;
            ph_hi   <= ph_hi_n;
            pwm_out <= pwm_n;
            for (int i = 0; i < NUM_CH; i++) begin
                h_a[i] <= h_n[i];
                l_a[i] <= l_n[i];
                cnt[i] <= cnt_n[i];
                if (hit[i]) begin
                    en_s[i]  <= hdr[7];
                    pol_s[i] <= hdr[6];
                    h_s[i]   <= h_new;
                    l_s[i]   <= l_new;
                end
            end
        end
    end

    assign ch_active = en_a;

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Bench for pwm_multi_generator: directed frame table, hand sequences and
// random frames checked against a period-position model of each channel.
module tb_pwm_multi_generator;
    localparam int NCH = 4;

    logic           clk;
    logic           rst;
    logic           empty;
    logic [7:0]     i_data;
    logic           read;
    logic [NCH-1:0] pwm_out;
    logic [NCH-1:0] ch_active;
    logic           frame_done;
    logic           frame_err;

    pwm_multi_generator dut (
        .clk        (clk),
        .rst        (rst),
        .empty      (empty),
        .i_data     (i_data),
        .read       (read),
        .pwm_out    (pwm_out),
        .ch_active  (ch_active),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q [$];

    // channel model: position inside the current H+L period
    bit     a_en [NCH];
    bit     a_pol[NCH];
    longint a_h  [NCH];
    longint a_l  [NCH];
    longint pos  [NCH];
    bit     s_en [NCH];
    bit     s_pol[NCH];
    longint s_h  [NCH];
    longint s_l  [NCH];
    bit     pend [NCH];
    int     commit_in;
    logic [7:0] c_hdr;
    longint c_h, c_l;
    bit     m_done, m_err;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %h expected %h",
                         name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit b;
        int idx;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                a_en[c] = 0; a_pol[c] = 0; a_h[c] = 0; a_l[c] = 0;
                s_en[c] = 0; s_pol[c] = 0; s_h[c] = 0; s_l[c] = 0;
                pos[c] = 0; pend[c] = 0;
            end
            commit_in = 0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            b = !a_en[c] || (a_h[c] + a_l[c] == 0) ||
                (pos[c] == a_h[c] + a_l[c] - 1);
            if (b && pend[c]) begin
                a_en[c] = s_en[c]; a_pol[c] = s_pol[c];
                a_h[c] = s_h[c];   a_l[c] = s_l[c];
                pend[c] = 0;
                pos[c] = 0;
            end else if (b) begin
                pos[c] = 0;
            end else begin
                pos[c] = pos[c] + 1;
            end
        end
        if (commit_in > 0) begin
            commit_in--;
            if (commit_in == 0) begin
                idx = int'(c_hdr[5:0]);
                if (idx < NCH) begin
                    s_en[idx] = c_hdr[7]; s_pol[idx] = c_hdr[6];
                    s_h[idx] = c_h; s_l[idx] = c_l;
                    pend[idx] = 1;
                    m_done = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NCH-1:0] ep, ea;
        for (int c = 0; c < NCH; c++) begin
            ep[c] = a_en[c] ? ((pos[c] < a_h[c]) ^ a_pol[c]) : a_pol[c];
            ea[c] = a_en[c];
        end
        chk("model_pwm", 64'(pwm_out), 64'(ep));
        chk("model_active", 64'(ch_active), 64'(ea));
        chk("model_done", 64'(frame_done), 64'(m_done));
        chk("model_err", 64'(frame_err), 64'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (read === 1'b1 && fifo_q.size() > 0) i_data = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_read", 64'(read), 64'(0));
        chk("rst_pwm", 64'(pwm_out), 64'(0));
        chk("rst_active", 64'(ch_active), 64'(0));
        chk("rst_done_err", 64'({frame_done, frame_err}), 64'(0));
        rst = 1'b0;
        fifo_q.delete();
        empty = 1'b1;
    endtask

    task automatic push_frame(logic [7:0] hdr, logic [31:0] h,
                              logic [31:0] l, int nbytes);
        logic [7:0] b [9];
        b[0] = hdr;
        for (int k = 0; k < 4; k++) begin
            b[1+k] = h[31-8*k -: 8];
            b[5+k] = l[31-8*k -: 8];
        end
        for (int k = 0; k < nbytes; k++) fifo_q.push_back(b[k]);
        empty = 1'b0;
    endtask

    // nine bytes at three cycles each, plus the commit cycle
    task automatic send_frame(logic [7:0] hdr, logic [31:0] h, logic [31:0] l);
        push_frame(hdr, h, l, 9);
        c_hdr = hdr; c_h = longint'(h); c_l = longint'(l);
        commit_in = 28;
        repeat (28) tick();
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] h;
        logic [31:0] l;
        int          ch;
        bit          done;
        logic [15:0] wave;
        logic [3:0]  act;
        bit          rst_first;
    } vec_t;

    function automatic vec_t mk(logic [7:0] hdr, int h, int l, int ch,
                                bit done, logic [15:0] wave,
                                logic [3:0] act, bit rf);
        vec_t v;
        v.hdr = hdr; v.h = 32'(h); v.l = 32'(l); v.ch = ch;
        v.done = done; v.wave = wave; v.act = act; v.rst_first = rf;
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        logic [7:0]  hdr;
        logic [31:0] h, l;
        logic [11:0] seq;
        int          gap;

        vecs[0] = mk(8'h80, 3, 2, 0, 1, 16'b1110011100111001, 4'b0001, 1);
        vecs[1] = mk(8'hC2, 2, 6, 2, 1, 16'b0011111100111111, 4'b0100, 1);
        vecs[2] = mk(8'h81, 0, 5, 1, 1, 16'h0000, 4'b0010, 1);
        vecs[3] = mk(8'h83, 5, 0, 3, 1, 16'hFFFF, 4'b1000, 1);
        vecs[4] = mk(8'h80, 0, 0, 0, 1, 16'h0000, 4'b0001, 1);
        vecs[5] = mk(8'h85, 3, 2, 0, 0, 16'h0000, 4'b0000, 1);
        vecs[6] = mk(8'hC1, 1, 1, 1, 1, 16'h5555, 4'b0010, 0);
        vecs[7] = mk(8'h43, 4, 4, 3, 1, 16'hFFFF, 4'b0000, 1);
        vecs[8] = mk(8'h81, 1, 3, 1, 1, 16'h8888, 4'b0010, 1);

        rst = 1'b1; empty = 1'b1; i_data = 8'h00; commit_in = 0;
        tick();
        do_reset();

        for (int t = 0; t < 9; t++) begin
            if (vecs[t].rst_first) do_reset();
            send_frame(vecs[t].hdr, vecs[t].h, vecs[t].l);
            chk("vec_done", 64'(frame_done), 64'(vecs[t].done));
            chk("vec_err", 64'(frame_err), 64'(!vecs[t].done));
            for (int k = 0; k < 16; k++) begin
                tick();
                chk("vec_wave", 64'(pwm_out[vecs[t].ch]),
                    64'(vecs[t].wave[15-k]));
            end
            chk("vec_active", 64'(ch_active), 64'(vecs[t].act));
        end

        // retune ch1 mid-HIGH: current 8-cycle period must finish intact
        do_reset();
        send_frame(8'h81, 4, 4);
        repeat (6) tick();
        send_frame(8'h81, 1, 1);
        seq = 12'b110000101010;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("retune_wave", 64'(pwm_out[1]), 64'(seq[11-k]));
        end

        // inverted ch2 then disabled with pol=1: idles high
        do_reset();
        send_frame(8'hC2, 2, 6);
        send_frame(8'h42, 0, 0);
        repeat (8) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("idle_high", 64'(pwm_out[2]), 64'(1));
        end
        chk("idle_active", 64'(ch_active[2]), 64'(0));

        // reset after four bytes of a frame, then a clean frame
        do_reset();
        send_frame(8'h80, 3, 2);
        push_frame(8'h83, 32'd7, 32'd7, 4);
        repeat (12) tick();
        do_reset();
        send_frame(8'h82, 2, 2);
        chk("post_rst_done", 64'(frame_done), 64'(1));
        seq = 12'b110011001100;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("post_rst_wave", 64'(pwm_out[2]), 64'(seq[11-k]));
        end

        // random frames, including bad indices and pending overwrites
        do_reset();
        for (int r = 0; r < 30; r++) begin
            hdr = {($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                   6'($urandom_range(0, 5))};
            h = 32'($urandom_range(0, 40));
            l = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 5) == 0) h = 0;
            if ($urandom_range(0, 5) == 0) l = 0;
            send_frame(hdr, h, l);
            gap = int'($urandom_range(0, 20));
            repeat (gap) tick();
        end
        repeat (100) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi_generator.md
# pwm_multi_generator

Multi-channel successor to the single-channel FIFO-fed PWM generator. It pops byte frames from the command FIFO and assembles per-channel high/low period, enable and polarity into shadow registers. It applies them glitch-free at each channel's period boundary and drives NUM_CH independent PWM outputs. It sits between the command FIFO and the PWM pins.

## Interface
- NUM_CH, 4, number of PWM channels (1..64)
- COUNTER_WIDTH, 32, width of each period field; must be a multiple of 8
- PWM_FIFO_WIDTH, 8, FIFO word width; fixed at 8 in this block
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- empty  in  1  FIFO empty flag
- i_data  in  PWM_FIFO_WIDTH  FIFO read data, valid in the cycle after `read` is high
- read  out  1  FIFO pop strobe, registered, one cycle wide
- pwm_out  out  NUM_CH  PWM outputs, registered
- ch_active  out  NUM_CH  per-channel applied enable bit
- frame_done  out  1  one-cycle pulse when a valid frame is committed
- frame_err  out  1  one-cycle pulse when a frame is discarded

## Operation
- Frame format: FRAME_BYTES = 1 + 2*COUNTER_WIDTH/8 (9 at default).
  - Header byte: bit7 = enable, bit6 = polarity invert, bits[5:0] = channel index.
  - Then HIGH period, MSB byte first.
  - Then LOW period, MSB byte first.
- Frame FSM states: IDLE, REQ, CAPTURE, COMMIT.
  - IDLE -> REQ when !empty; `read`=1 throughout REQ only.
  - REQ -> CAPTURE unconditionally.
  - CAPTURE shifts i_data into the assembly register and increments byte_cnt. It goes to COMMIT when byte_cnt reaches FRAME_BYTES-1, else to IDLE.
  - COMMIT: if index < NUM_CH, write shadow {en, pol, H, L}, set pending[idx] and pulse frame_done. Otherwise discard and pulse frame_err. Clear byte_cnt, then go to IDLE.
- A later frame to a channel whose pending is still set overwrites the shadow; last write wins and no error is raised.
- Per channel: phase (HIGH/LOW) and down-counter ph_cnt.
  - Boundary = channel disabled, or LOW phase with ph_cnt==0, or (HIGH phase with ph_cnt==0 and applied L==0).
  - On a boundary with pending set: load active regs from shadow, clear pending, start a new period.
  - New period: if H>0, phase=HIGH and ph_cnt=H-1; else phase=LOW and ph_cnt=L-1.
  - HIGH phase, ph_cnt==0: go to LOW with ph_cnt=L-1 if L>0; else start a new period.
- Output, when enabled: pwm_out = (phase==HIGH) XOR pol.
  - H=0, L>0: constant inactive level.
  - L=0, H>0: constant active level.
  - H=0 and L=0: channel holds the inactive level and treats every cycle as a boundary.
- When disabled: pwm_out = pol (idle level). ch_active mirrors the applied enable.
- Arithmetic: period = H+L cycles. Counters are COUNTER_WIDTH wide, unsigned, and never wrap below 0.

## Timing
- Reset (any cycle, including mid-frame): `read`, pwm_out, ch_active, frame_done and frame_err are all 0. FSM goes to IDLE, byte_cnt=0, all shadow/active/pending regs cleared.
  - A partially received frame is dropped.
  - A byte popped in REQ but not yet captured is lost.
- Byte throughput: 3 cycles per byte with a non-empty FIFO. Full frame at default: 27 cycles + 1 COMMIT cycle.
- frame_done/frame_err are high in the cycle after the COMMIT edge.
- If a channel is disabled at COMMIT edge C, it loads at edge C+1. pwm_out shows the first phase from edge C+1 and holds exactly H cycles high, then L cycles low.
- A running channel applies new settings on the first edge after its current period ends; the current period is never truncated.
- `empty` is sampled only in IDLE.

## Test plan
- Reset, then frame {0x80, H=3, L=2} to ch0 -> frame_done one pulse; ch0 pattern 1,1,1,0,0 repeating from edge C+1; other channels 0.
- ch1 running H=4/L=4; new frame H=1/L=1 sent mid-HIGH -> current 8-cycle period completes, then 1/1 toggling; no short pulse.
- Header 0xC2 (en, pol, ch2) with H=2/L=6 -> ch2 low 2, high 6; after an en=0 frame, ch2 holds 1.
- Header index 5 with NUM_CH=4 -> frame_err one pulse, no channel changes; next valid frame accepted normally.
- H=0/L=5 -> constant 0; H=5/L=0 -> constant 1; H=0/L=0 -> constant 0.
- Assert rst after 4 bytes of a frame -> outputs 0, next complete frame decodes from a fresh header.
